ps2_key_tracker_multi: RTL and testbench

//  Parametrised PS/2 keyboard tracker: receives PS/2 device-to-host frames, decodes make/break

---
 rtl/ps2_key_tracker_multi.sv | 244 ++++++++++++++++++++++++
 tb/tb_ps2_key_tracker_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker_multi.sv
// PS/2 keyboard receiver with clock deglitching, frame checking, make/break decoding
// (including E0 extended codes) and per-key hold or pulse outputs.
module ps2_key_tracker_multi #(
    parameter int                   N_KEYS         = 10,
    parameter logic [9*N_KEYS-1:0]  KEY_CODES      = {9'h05A, 9'h029, 9'h172, 9'h175, 9'h174,
                                                      9'h16B, 9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter logic [N_KEYS-1:0]    PULSE_MASK     = '0,
    parameter int                   FILTER_LEN     = 4,
    parameter int                   TIMEOUT_CYCLES = 10000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ps2_clk,
    input  logic              i_ps2_dat,
    output logic [N_KEYS-1:0] o_keys,
    output logic              o_code_valid,
    output logic [8:0]        o_code,
    output logic              o_code_break,
    output logic              o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } dec_state_t;

    logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic          r_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          w_filt_flip, w_fall;

    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;
    logic          r_byte_stb;
    logic [7:0]    r_byte;
    logic          r_abort;
    logic          r_frame_err;

    dec_state_t    r_state, w_state_next;
    logic          w_ignored;
    logic          w_dec_valid;
    logic [8:0]    w_dec_code;
    logic          w_dec_break;

    logic          r_code_valid;
    logic [8:0]    r_code;
    logic          r_code_break;

    // Both pins idle high, so the synchronisers reset to 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign w_filt_flip = (r_clk_sync != r_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall      = w_filt_flip && r_filt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_sync == r_filt) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt     <= r_clk_sync;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    assign w_timeout = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_stb  <= 1'b0;
            r_byte      <= 8'h00;
            r_abort     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_stb  <= 1'b0;
            r_abort     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_bit_cnt)
                    4'd0: begin
                        if (r_dat_sync) r_frame_err <= 1'b1;
                        else            r_bit_cnt   <= 4'd1;
                    end
                    4'd9: begin
                        r_par     <= r_dat_sync;
                        r_bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        r_bit_cnt <= 4'd0;
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        if (r_dat_sync && (^{r_shift, r_par})) begin
                            r_byte_stb <= 1'b1;
                            r_byte     <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_abort     <= 1'b1;
                        end
                    end
                    default: begin
                        r_shift   <= {r_dat_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                endcase
            end else if (r_bit_cnt != 4'd0) begin
                if (w_timeout) begin
                    r_bit_cnt   <= 4'd0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                    r_abort     <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Keyboard status replies and reserved bytes never form a key code.
    assign w_ignored = (r_byte == 8'hAA) || (r_byte == 8'hFA) || (r_byte == 8'hFE) ||
                       (r_byte == 8'hEE) || (r_byte == 8'h00) || (r_byte == 8'hFF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_dec_valid  = 1'b0;
        w_dec_code   = 9'h000;
        w_dec_break  = 1'b0;
        if (r_abort) begin
            w_state_next = S_IDLE;
        end else if (r_byte_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hE0) begin
                        w_state_next = S_EXT;
                    end else if (r_byte == 8'hF0) begin
                        w_state_next = S_BRK;
                    end else if (!w_ignored) begin
                        w_dec_valid = 1'b1;
                        w_dec_code  = {1'b0, r_byte};
                    end
                end
                S_EXT: begin
                    if (r_byte == 8'hF0) begin
                        w_state_next = S_EXT_BRK;
                    end else if (r_byte != 8'hE0) begin
                        w_dec_valid  = 1'b1;
                        w_dec_code   = {1'b1, r_byte};
                        w_state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_dec_valid  = 1'b1;
                    w_dec_break  = 1'b1;
                    w_dec_code   = {1'b0, r_byte};
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_dec_valid  = 1'b1;
                    w_dec_break  = 1'b1;
                    w_dec_code   = {1'b1, r_byte};
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code_valid <= 1'b0;
            r_code       <= 9'h000;
            r_code_break <= 1'b0;
        end else begin
            r_code_valid <= w_dec_valid;
            if (w_dec_valid) begin
                r_code       <= w_dec_code;
                r_code_break <= w_dec_break;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic w_match;
            logic r_hold;
            logic r_pulse;

            assign w_match = w_dec_valid && (w_dec_code == KEY_CODES[9*gi +: 9]);

            // Pulse only on a fresh press; typematic repeats arrive while already held.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_hold  <= 1'b0;
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= w_match && !w_dec_break && !r_hold;
                    if (w_match) r_hold <= !w_dec_break;
                end
            end

            assign o_keys[gi] = PULSE_MASK[gi] ? r_pulse : r_hold;
        end
    endgenerate

    assign o_code_valid = r_code_valid;
    assign o_code       = r_code;
    assign o_code_break = r_code_break;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker_multi.sv
// Scoreboard bench for ps2_key_tracker_multi: PS/2 frames are bit-banged and every
// decoded code is checked against a queue of expected codes.
module tb_ps2_key_tracker_multi;

    localparam int N_KEYS  = 10;
    localparam int TIMEOUT = 500;
    localparam int HALF    = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ps2_clk;
    logic              ps2_dat;
    logic [N_KEYS-1:0] o_keys;
    logic              o_code_valid;
    logic [8:0]        o_code;
    logic              o_code_break;
    logic              o_frame_err;

    typedef struct packed {
        logic [8:0] code;
        logic       brk;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_err   = 0;
    int   n_pulse = 0;
    int   run     = 0;
    int   max_run = 0;

    ps2_key_tracker_multi #(
        .N_KEYS        (N_KEYS),
        .PULSE_MASK    (10'b00_0000_0001),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_dat   (ps2_dat),
        .o_keys      (o_keys),
        .o_code_valid(o_code_valid),
        .o_code      (o_code),
        .o_code_break(o_code_break),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard on every code strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (o_code_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_code got code=%h brk=%b, expected no strobe", o_code, o_code_break);
                end else begin
                    e = q.pop_front();
                    if (o_code !== e.code || o_code_break !== e.brk) begin
                        n_fail++;
                        $display("FAIL code_check got code=%h brk=%b, expected code=%h brk=%b",
                                 o_code, o_code_break, e.code, e.brk);
                    end else begin
                        $display("[TB] code=%h brk=%b ok", o_code, o_code_break);
                    end
                end
            end
            if (o_frame_err) n_err++;
            if (o_keys[0]) begin
                run++;
                if (run == 1) n_pulse++;
            end else begin
                if (run > max_run) max_run = run;
                run = 0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            if (i == glitch_bit) begin
                repeat (HALF / 2) @(negedge clk);
                ps2_clk = 1'b0;
                @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
    endtask

    task automatic expect_code(input logic [8:0] c, input logic brk);
        exp_t e;
        e.code = c;
        e.brk  = brk;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got %0d codes pending, expected 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (o_keys !== '0 || o_code_valid !== 1'b0 || o_code !== 9'h000 ||
            o_code_break !== 1'b0 || o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got keys=%h v=%b code=%h brk=%b err=%b, expected all 0",
                     o_keys, o_code_valid, o_code, o_code_break, o_frame_err);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if (o_keys !== '0 || o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got keys=%h err=%b, expected 0 0", o_keys, o_frame_err);
        end
    endtask

    task automatic test_hold_make_break();
        expect_code(9'h029, 1'b0);
        send(8'h29);
        drain("space_make");
        n_tests++;
        if (o_keys[8] !== 1'b1 || o_code_break !== 1'b0) begin
            n_fail++;
            $display("FAIL space_make got key8=%b brk=%b, expected 1 0", o_keys[8], o_code_break);
        end
        expect_code(9'h029, 1'b1);
        send(8'hF0);
        send(8'h29);
        drain("space_break");
        n_tests++;
        if (o_keys[8] !== 1'b0 || o_code_break !== 1'b1 || o_code !== 9'h029) begin
            n_fail++;
            $display("FAIL space_break got key8=%b brk=%b code=%h, expected 0 1 029",
                     o_keys[8], o_code_break, o_code);
        end
    endtask

    task automatic test_extended();
        send(8'hE0);
        n_tests++;
        if (o_keys[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_prefix got key4=%b, expected 0", o_keys[4]);
        end
        expect_code(9'h16B, 1'b0);
        send(8'h6B);
        drain("left_make");
        n_tests++;
        if (o_keys[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL left_make got key4=%b, expected 1", o_keys[4]);
        end
        expect_code(9'h16B, 1'b1);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        drain("left_break");
        n_tests++;
        if (o_keys[4] !== 1'b0 || o_code !== 9'h16B) begin
            n_fail++;
            $display("FAIL left_break got key4=%b code=%h, expected 0 16b", o_keys[4], o_code);
        end
    endtask

    task automatic test_pulse();
        n_pulse = 0;
        max_run = 0;
        for (int i = 0; i < 3; i++) begin
            expect_code(9'h01D, 1'b0);
            send(8'h1D);
        end
        expect_code(9'h01D, 1'b1);
        send(8'hF0);
        send(8'h1D);
        expect_code(9'h01D, 1'b0);
        send(8'h1D);
        drain("pulse");
        n_tests++;
        if (n_pulse !== 2 || max_run !== 1 || o_keys[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_count got pulses=%0d width=%0d key0=%b, expected 2 1 0",
                     n_pulse, max_run, o_keys[0]);
        end
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = n_err;
        send_frame(8'h1C, 1'b1, 11, -1);
        n_tests++;
        if (n_err !== e0 + 1 || o_keys[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err got err_cycles=%0d key1=%b, expected 1 0", n_err - e0, o_keys[1]);
        end
        expect_code(9'h01C, 1'b0);
        send(8'h1C);
        drain("after_parity");
        n_tests++;
        if (o_keys[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_parity got key1=%b, expected 1", o_keys[1]);
        end
    endtask

    task automatic test_timeout_glitch();
        int e0;
        e0 = n_err;
        send_frame(8'h23, 1'b0, 5, -1);
        repeat (TIMEOUT + 100) @(negedge clk);
        n_tests++;
        if (n_err !== e0 + 1) begin
            n_fail++;
            $display("FAIL timeout_err got err_cycles=%0d, expected 1", n_err - e0);
        end
        expect_code(9'h023, 1'b0);
        send(8'h23);
        drain("after_timeout");
        n_tests++;
        if (o_keys[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_timeout got key3=%b, expected 1", o_keys[3]);
        end
        e0 = n_err;
        expect_code(9'h01B, 1'b0);
        send_frame(8'h1B, 1'b0, 11, 4);
        drain("glitch");
        n_tests++;
        if (o_keys[2] !== 1'b1 || n_err !== e0) begin
            n_fail++;
            $display("FAIL glitch got key2=%b err_cycles=%0d, expected 1 0", o_keys[2], n_err - e0);
        end
    endtask

    task automatic test_reset_midframe();
        send(8'hE0);
        send_frame(8'h75, 1'b0, 4, -1);
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_keys !== '0 || o_code !== 9'h000 || o_code_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset got keys=%h code=%h v=%b, expected 0 0 0",
                     o_keys, o_code, o_code_valid);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        expect_code(9'h075, 1'b0);
        send(8'h75);
        drain("post_reset");
        n_tests++;
        if (o_code !== 9'h075 || o_keys[6] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got code=%h key6=%b, expected 075 0", o_code, o_keys[6]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_hold_make_break();
        test_extended();
        test_pulse();
        test_parity_err();
        test_timeout_glitch();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
